// File: rtl/arb2x1_rr.sv
// arb2x1_rr: two-input round-robin arbiter with burst-held grants,
// valid/ready handshakes and a one-entry registered output stage.
// Drives the downstream 2:1 mux select `s`.
module arb2x1_rr #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i0_valid,
  input  logic [DATA_W-1:0] i0_data,
  output logic              i0_ready,
  input  logic              i1_valid,
  input  logic [DATA_W-1:0] i1_data,
  output logic              i1_ready,
  output logic              s,
  output logic              y_valid,
  output logic [DATA_W-1:0] y_data,
  input  logic              y_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  localparam logic [3:0] BEAT_LAST = 4'(BURST - 1);

  logic [1:0]        state;
  logic [3:0]        beat;
  logic              last;

  logic              can_accept;
  logic              xfer0;
  logic              xfer1;
  logic              xfer;
  logic [DATA_W-1:0] xdata;
  logic              release_now;

  // Handshake decode: readies, accepted beat and grant release condition.
  // Readies are held low while rst is high so no beat is taken in the reset cycle.
  always_comb begin
    can_accept  = !y_valid || y_ready;
    i0_ready    = !rst && (state == G0) && can_accept;
    i1_ready    = !rst && (state == G1) && can_accept;
    xfer0       = i0_valid && i0_ready;
    xfer1       = i1_valid && i1_ready;
    xfer        = xfer0 || xfer1;
    xdata       = xfer1 ? i1_data : i0_data;
    release_now = 1'b0;
    case (state)
      G0:      release_now = can_accept && (!i0_valid || (beat == BEAT_LAST));
      G1:      release_now = can_accept && (!i1_valid || (beat == BEAT_LAST));
      default: release_now = 1'b0;
    endcase
  end

  // Output register: load on transfer, otherwise clear when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid <= 1'b0;
      y_data  <= '0;
    end else if (xfer) begin
      y_valid <= 1'b1;
      y_data  <= xdata;
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

  // Grant FSM with beat counter and round-robin priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      last  <= 1'b1;
      s     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i0_valid && (!i1_valid || last)) begin
            state <= G0;
            s     <= 1'b0;
            beat  <= '0;
          end else if (i1_valid) begin
            state <= G1;
            s     <= 1'b1;
            beat  <= '0;
          end
        end
        G0: begin
          if (xfer0) beat <= beat + 4'd1;
          if (release_now) begin
            state <= IDLE;
            last  <= 1'b0;
          end
        end
        G1: begin
          if (xfer1) beat <= beat + 4'd1;
          if (release_now) begin
            state <= IDLE;
            last  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb2x1_rr.sv
// Scoreboard bench for arb2x1_rr: directed source queues feed the
// inputs, expected {s,data} pairs are queued, a monitor checks each
// output handshake. A second instance is built with BURST=1.
module tb_arb2x1_rr;

  logic       clk;
  logic       rst;
  logic       i0_valid, i1_valid;
  logic [7:0] i0_data, i1_data;
  logic       y_ready;
  logic       use_b1;

  logic       a_i0_ready, a_i1_ready, a_s, a_y_valid;
  logic [7:0] a_y_data;
  logic       b_i0_ready, b_i1_ready, b_s, b_y_valid;
  logic [7:0] b_y_data;

  logic       m_i0_ready, m_i1_ready, m_s, m_y_valid;
  logic [7:0] m_y_data;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned n_pop   = 0;
  int unsigned t_start = 0;

  logic [8:0]  exp_q[$];
  logic [7:0]  src0[$];
  logic [7:0]  src1[$];
  int unsigned pop_t[$];

  arb2x1_rr #(.DATA_W(8), .BURST(4)) u_a (
    .clk(clk), .rst(rst),
    .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(a_i0_ready),
    .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(a_i1_ready),
    .s(a_s), .y_valid(a_y_valid), .y_data(a_y_data), .y_ready(y_ready)
  );

  arb2x1_rr #(.DATA_W(8), .BURST(1)) u_b (
    .clk(clk), .rst(rst),
    .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(b_i0_ready),
    .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(b_i1_ready),
    .s(b_s), .y_valid(b_y_valid), .y_data(b_y_data), .y_ready(y_ready)
  );

  assign m_i0_ready = use_b1 ? b_i0_ready : a_i0_ready;
  assign m_i1_ready = use_b1 ? b_i1_ready : a_i1_ready;
  assign m_s        = use_b1 ? b_s        : a_s;
  assign m_y_valid  = use_b1 ? b_y_valid  : a_y_valid;
  assign m_y_data   = use_b1 ? b_y_data   : a_y_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Source driver: present the head of each queue, pop it once accepted.
  initial begin
    logic a0, a1, was_idle;
    i0_valid = 1'b0; i1_valid = 1'b0;
    i0_data  = '0;   i1_data  = '0;
    forever begin
      @(negedge clk);
      a0 = i0_valid && m_i0_ready;
      a1 = i1_valid && m_i1_ready;
      @(posedge clk);
      #1;
      if (a0 && src0.size() != 0) void'(src0.pop_front());
      if (a1 && src1.size() != 0) void'(src1.pop_front());
      was_idle = !i0_valid && !i1_valid;
      i0_valid = (src0.size() != 0);
      i0_data  = (src0.size() != 0) ? src0[0] : 8'h00;
      i1_valid = (src1.size() != 0);
      i1_data  = (src1.size() != 0) ? src1[0] : 8'h00;
      if (was_idle && (i0_valid || i1_valid)) t_start = cyc;
    end
  end

  // Monitor: every output handshake is compared against the queue head.
  always @(negedge clk) begin
    if (!rst && m_y_valid && y_ready) begin
      logic [8:0] e;
      n_pop++;
      pop_t.push_back(cyc);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got s=%0d data=%02h, required no beat", m_s, m_y_data);
      end else begin
        e = exp_q.pop_front();
        if ({m_s, m_y_data} !== e)
          begin
            n_fail++;
            $display("FAIL beat: got s=%0d data=%02h, required s=%0d data=%02h",
                     m_s, m_y_data, e[8], e[7:0]);
          end
      end
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input logic sel, input logic [7:0] d);
    exp_q.push_back({sel, d});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    pop_t.delete();
    n_pop = 0;
    @(negedge clk);
    src0.delete();
    src1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int unsigned lim);
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < lim) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d beats left, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; y_ready = 1'b1; use_b1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_y_valid",  32'(m_y_valid),  0);
    chk("rst_y_data",   32'(m_y_data),   0);
    chk("rst_s",        32'(m_s),        0);
    chk("rst_i0_ready", 32'(m_i0_ready), 0);
    chk("rst_i1_ready", 32'(m_i1_ready), 0);

    // Single channel burst: latency 2 from valid, back-to-back beats
    do_reset();
    @(negedge clk);
    push(0, 8'h11); push(0, 8'h12); push(0, 8'h13); push(0, 8'h14);
    src0.push_back(8'h11); src0.push_back(8'h12);
    src0.push_back(8'h13); src0.push_back(8'h14);
    wait_drain("single", 100);
    chk("single_pops", pop_t.size(), 4);
    if (pop_t.size() == 4) begin
      chk("single_latency", pop_t[0] - t_start, 2);
      chk("single_span",    pop_t[3] - pop_t[0], 3);
    end

    // Both channels contending: bursts of 4, channel 0 first
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(0, 8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) push(1, 8'hB0 + 8'(i));
    for (int i = 4; i < 8; i++) push(0, 8'hA0 + 8'(i));
    for (int i = 4; i < 8; i++) push(1, 8'hB0 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      src0.push_back(8'hA0 + 8'(i));
      src1.push_back(8'hB0 + 8'(i));
    end
    wait_drain("rr", 200);
    chk("rr_pops", pop_t.size(), 16);
    if (pop_t.size() == 16) begin
      chk("rr_burst_span", pop_t[3] - pop_t[0], 3);
      chk("rr_bubble",     pop_t[4] - pop_t[3], 2);
    end

    // Channel 1 with backpressure mid-burst
    do_reset();
    @(negedge clk);
    push(1, 8'hC0); push(1, 8'hC1); push(1, 8'hC2); push(1, 8'hC3);
    src1.push_back(8'hC0); src1.push_back(8'hC1);
    src1.push_back(8'hC2); src1.push_back(8'hC3);
    begin
      int unsigned k = 0;
      while (n_pop < 2 && k < 50) begin
        @(posedge clk);
        k++;
      end
      chk("bp_reach2", (n_pop >= 2) ? 1 : 0, 1);
    end
    #1 y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_y_data",   32'(m_y_data),   32'h0C2);
      chk("bp_y_valid",  32'(m_y_valid),  1);
      chk("bp_i1_ready", 32'(m_i1_ready), 0);
    end
    @(posedge clk); #1 y_ready = 1'b1;
    wait_drain("bp", 100);
    chk("bp_pops", pop_t.size(), 4);

    // Channel 0 drops valid early, channel 1 waiting
    do_reset();
    @(negedge clk);
    push(0, 8'hD0); push(0, 8'hD1); push(1, 8'hE0);
    src0.push_back(8'hD0); src0.push_back(8'hD1);
    src1.push_back(8'hE0);
    wait_drain("drop", 100);
    chk("drop_pops", pop_t.size(), 3);
    if (pop_t.size() == 3) chk("drop_gap", pop_t[2] - pop_t[1], 3);

    // Reset while the output register holds a beat in G0
    do_reset();
    @(posedge clk); #1 y_ready = 1'b0;
    @(negedge clk);
    push(0, 8'hF1); push(0, 8'hF2); push(0, 8'hF3); push(1, 8'h70); push(1, 8'h71);
    for (int i = 0; i < 4; i++) src0.push_back(8'hF0 + 8'(i));
    src1.push_back(8'h70); src1.push_back(8'h71);
    begin
      int unsigned k = 0;
      while (!m_y_valid && k < 50) begin
        @(negedge clk);
        k++;
      end
      chk("mrst_loaded", 32'(m_y_valid), 1);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mrst_cyc_i0_ready", 32'(m_i0_ready), 0);
    chk("mrst_cyc_i1_ready", 32'(m_i1_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_y_valid",  32'(m_y_valid),  0);
    chk("mrst_s",        32'(m_s),        0);
    chk("mrst_i0_ready", 32'(m_i0_ready), 0);
    chk("mrst_i1_ready", 32'(m_i1_ready), 0);
    @(posedge clk); #1 y_ready = 1'b1;
    wait_drain("mrst", 100);

    // BURST=1 instance: strict alternation with an IDLE bubble
    use_b1 = 1'b1;
    do_reset();
    @(negedge clk);
    push(0, 8'h30); push(1, 8'h40); push(0, 8'h31);
    push(1, 8'h41); push(0, 8'h32); push(1, 8'h42);
    for (int i = 0; i < 3; i++) begin
      src0.push_back(8'h30 + 8'(i));
      src1.push_back(8'h40 + 8'(i));
    end
    wait_drain("b1", 100);
    chk("b1_pops", pop_t.size(), 6);
    if (pop_t.size() == 6)
      for (int i = 0; i < 5; i++) chk("b1_gap", pop_t[i+1] - pop_t[i], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
